// File: rtl/aes_stream_if.sv
// aes_stream_if: 32-bit valid/ready input stream and result output stream of aes_stream_ctrl
interface aes_stream_if;
  logic s_valid, s_ready, s_new_key, m_valid, m_ready, m_last;
  logic [31:0] s_data, m_data;
  modport master(output s_valid, s_data, s_new_key, m_ready, input s_ready, m_valid, m_data, m_last);
  modport slave(input s_valid, s_data, s_new_key, m_ready, output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: streams key/data words into AES_CORE, restarts it per block and streams the result out
// Optional key reuse across frames when AES_KEY_CACHE_EN is defined.
module aes_stream_ctrl #(
  parameter int CORE_RST_CYC = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  aes_stream_if.slave  s,
  output logic         err,
  output logic         busy,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key,
  output logic         core_rst_n,
  input  logic [127:0] core_data_out,
  input  logic         core_finished
);
  localparam int W = $clog2(TIMEOUT_CYC + CORE_RST_CYC + 4) + 1;
  typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_DATA, RST_CORE, RUN, OUT} state_t;
  state_t state;
  logic [127:0] key, data, result;
  logic [W-1:0] cnt;
  logic [1:0] w;
  logic hs, mhs, new_key;
  assign w = cnt[1:0];
  assign hs = s.s_valid & s.s_ready;
  assign mhs = s.m_valid & s.m_ready;
`ifdef AES_KEY_CACHE_EN
  assign new_key = s.s_new_key;
`else
  logic unused;
  assign unused = s.s_new_key;
  assign new_key = 1'b1;
`endif
  assign core_key = key;
  assign core_data_in = data;
  assign s.m_data = result[{~w, 5'd0} +: 32];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      key <= '0;
      data <= '0;
      result <= '0;
      cnt <= '0;
      s.s_ready <= 1'b0;
      s.m_valid <= 1'b0;
      s.m_last <= 1'b0;
      err <= 1'b0;
      busy <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          s.s_ready <= 1'b1;
          if (hs) begin
            busy <= 1'b1;
            cnt <= W'(1);
            if (new_key) begin
              key[127:96] <= s.s_data;
              state <= LOAD_KEY;
            end else begin
              data[127:96] <= s.s_data;
              state <= LOAD_DATA;
            end
          end
        end
        LOAD_KEY: if (hs) begin
          key[{~w, 5'd0} +: 32] <= s.s_data;
          cnt <= w == 2'd3 ? '0 : cnt + 1'b1;
          if (w == 2'd3) state <= LOAD_DATA;
        end
        LOAD_DATA: if (hs) begin
          data[{~w, 5'd0} +: 32] <= s.s_data;
          cnt <= w == 2'd3 ? '0 : cnt + 1'b1;
          if (w == 2'd3) begin
            state <= RST_CORE;
            s.s_ready <= 1'b0;
          end
        end
        RST_CORE: begin
          cnt <= cnt == W'(CORE_RST_CYC - 1) ? '0 : cnt + 1'b1;
          if (cnt == W'(CORE_RST_CYC - 1)) begin
            state <= RUN;
            core_rst_n <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          // a finished flag in the first cycle may be left over from the previous block
          if (core_finished && cnt != '0) begin
            result <= core_data_out;
            cnt <= '0;
            s.m_valid <= 1'b1;
            state <= OUT;
          end else if (cnt == W'(TIMEOUT_CYC - 1)) begin
            err <= 1'b1;
            cnt <= '0;
            core_rst_n <= 1'b0;
            busy <= 1'b0;
            s.s_ready <= 1'b1;
            state <= IDLE;
          end
        end
        OUT: if (mhs) begin
          cnt <= cnt + 1'b1;
          s.m_last <= w == 2'd2;
          if (w == 2'd3) begin
            cnt <= '0;
            s.m_valid <= 1'b0;
            s.m_last <= 1'b0;
            core_rst_n <= 1'b0;
            busy <= 1'b0;
            s.s_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: random-stimulus bench with a behavioural core stand-in and frame-level scoreboard
module tb_aes_stream_ctrl;
  localparam int C = 2, T = 64;
  localparam logic [127:0] V1K = 128'h000102030405060708090a0b0c0d0e0f, V1D = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1R = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2K = 128'h2b7e151628aed2a6abf7158809cf4f3c, V2D = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V2R = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V3K = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  logic clk = 0, rst_n = 1;
  logic err, busy, core_rst_n, core_finished;
  logic [127:0] core_data_in, core_key, core_data_out;
  aes_stream_if s();
  aes_stream_ctrl #(.CORE_RST_CYC(C), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .err(err), .busy(busy),
    .core_data_in(core_data_in), .core_key(core_key), .core_rst_n(core_rst_n),
    .core_data_out(core_data_out), .core_finished(core_finished));
  always #5 clk = ~clk;
  int compared = 0, mismatched = 0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tfail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got timeout expected event", name);
  endtask
  // core stand-in: known vectors for both builds, otherwise an arbitrary keyed mix
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] d);
    if (k == V1K && d == V1D) return V1R;
    if (k == V2K && d == V2D) return V2R;
    if (k == V3K && d == V2R) return V2D;
    return k ^ {d[63:0], d[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction
  int rc = 0, cur_lat = 1, nxt_lat = 1;
  bit cur_hang = 0, nxt_hang = 0, cur_stale = 0, nxt_stale = 0;
  always @(posedge clk) rc <= core_rst_n ? rc + 1 : 0;
  assign core_finished = core_rst_n && ((rc == 0 && cur_stale) || (!cur_hang && rc >= cur_lat));
  assign core_data_out = (rc == 0 && cur_stale) ? ~aes_ref(core_key, core_data_in) : aes_ref(core_key, core_data_in);
  int cyc = 0, last_hs = 0, err_at = -1, wcnt = 0, flen = 8, oidx = 0, errs = 0;
  bit active = 0, pending = 0, prev_stall = 0, prev_crn = 0;
  logic [127:0] mkey = '0, fkey = '0, fdata = '0, run_key = '0, run_data = '0, r;
  logic [31:0] q[$], got[$], prev_data = '0;
  always @(negedge clk) if (rst_n) begin
    cyc++;
    if (err) errs++;
    if (cyc == err_at) begin
      active = 0;
      pending = 0;
    end
    check("busy", busy, active);
    check("err", err, cyc == err_at);
    if (pending && active) check("s_ready_hold", s.s_ready, 0);
    if (s.s_ready) check("core_rst_n_load", core_rst_n, 0);
    if (core_rst_n) begin
      check("core_key", core_key, run_key);
      check("core_data_in", core_data_in, run_data);
    end
    if (core_rst_n && !prev_crn) begin
      check("rst_core_len", cyc - last_hs, C + 1);
      if (cur_hang) err_at = cyc + T;
    end
    if (q.size() == 0) check("m_valid_idle", s.m_valid, 0);
    if (s.m_valid) check("m_last", s.m_last, oidx == 3);
    if (prev_stall) begin
      check("stall_valid", s.m_valid, 1);
      check("stall_data", s.m_data, prev_data);
    end
    if (s.m_valid && s.m_ready && q.size() > 0) begin
      check("m_data", s.m_data, q[0]);
      got.push_back(s.m_data);
      void'(q.pop_front());
      if (oidx == 3) begin
        oidx = 0;
        active = 0;
        pending = 0;
      end else oidx++;
    end
    prev_stall = s.m_valid && !s.m_ready;
    prev_data = s.m_data;
    prev_crn = core_rst_n;
    if (s.s_valid && s.s_ready) begin
      if (wcnt == 0) begin
        active = 1;
`ifdef AES_KEY_CACHE_EN
        flen = s.s_new_key ? 8 : 4;
`else
        flen = 8;
`endif
        fkey = mkey;
      end
      if (flen == 8 && wcnt < 4) fkey[(3 - wcnt) * 32 +: 32] = s.s_data;
      else fdata[(3 - (wcnt - flen + 4)) * 32 +: 32] = s.s_data;
      wcnt++;
      if (wcnt == flen) begin
        wcnt = 0;
        pending = 1;
        mkey = fkey;
        run_key = fkey;
        run_data = fdata;
        last_hs = cyc;
        cur_lat = nxt_lat;
        cur_hang = nxt_hang;
        cur_stale = nxt_stale;
        r = aes_ref(fkey, fdata);
        if (!nxt_hang) for (int i = 0; i < 4; i++) q.push_back(r[127 - 32 * i -: 32]);
      end
    end
  end
  bit stall_req = 0;
  initial begin
    s.m_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req && s.m_valid && oidx == 2) begin
        s.m_ready = 0;
        repeat (5) @(posedge clk);
        #1;
        stall_req = 0;
      end
      s.m_ready = ($urandom_range(0, 3) != 0);
    end
  end
  task automatic do_reset();
    s.s_valid = 0;
    rst_n = 0;
    #1;
    check("rst_s_ready", s.s_ready, 0);
    check("rst_m_valid", s.m_valid, 0);
    check("rst_m_last", s.m_last, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_core_key", core_key, 0);
    check("rst_core_data_in", core_data_in, 0);
    q.delete();
    got.delete();
    wcnt = 0; active = 0; pending = 0; err_at = -1; oidx = 0;
    mkey = '0; prev_stall = 0; prev_crn = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  task automatic send_word(input logic [31:0] wd, input bit nk);
    int n = 0;
    while ($urandom_range(0, 2) == 0) begin
      s.s_valid = 0;
      @(posedge clk);
      #1;
    end
    s.s_valid = 1;
    s.s_data = wd;
    s.s_new_key = nk;
    forever begin
      @(negedge clk);
      if (s.s_ready) break;
      if (++n > 200) begin
        tfail("s_ready_wait");
        break;
      end
    end
    @(posedge clk);
    #1 s.s_valid = 0;
  endtask
  task automatic send_frame(input logic [127:0] k, input logic [127:0] d, input bit nk, input int lat, input bit hang, input bit stale);
    nxt_lat = lat;
    nxt_hang = hang;
    nxt_stale = stale;
    if (nk) for (int i = 0; i < 4; i++) send_word(k[127 - 32 * i -: 32], 1'b1);
    for (int i = 0; i < 4; i++) send_word(d[127 - 32 * i -: 32], (i == 0) ? nk : 1'b1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (active || pending) begin
      @(negedge clk);
      if (++n > 500) begin
        tfail("idle_wait");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic check_got(input string name, input logic [127:0] lit);
    check(name, got.size() == 4 ? {got[0], got[1], got[2], got[3]} : 128'hx, lit);
    got.delete();
  endtask
  int e0, n;
  initial begin
    s.s_valid = 0;
    s.s_data = '0;
    s.s_new_key = 1;
    #3 do_reset();
    send_frame(V1K, V1D, 1, 3, 0, 0);
    wait_idle();
    check_got("vec1_words", V1R);
    send_frame(V2K, V2D, 1, 5, 0, 1);
    wait_idle();
    check_got("vec2_words", V2R);
    send_frame(V3K, V2R, 1, 1, 0, 1);
    wait_idle();
    check_got("vec3_inv_words", V2D);
    stall_req = 1;
    send_frame({$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom(), $urandom(), $urandom()}, 1, 2, 0, 0);
    wait_idle();
    e0 = errs;
    send_frame({$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom(), $urandom(), $urandom()}, 1, 1, 1, 1);
    wait_idle();
    check("err_pulse_count", errs - e0, 1);
    got.delete();
    send_frame(V1K, V1D, 1, 4, 0, 0);
    wait_idle();
    check_got("after_timeout_words", V1R);
    send_frame(V2K, V2D, 1, T - 1, 0, 0);
    wait_idle();
    check_got("last_cycle_finish_words", V2R);
    nxt_hang = 0;
    for (int i = 0; i < 6; i++) send_word($urandom(), 1'b1);
    do_reset();
    send_frame(V2K, V2D, 1, 2, 0, 0);
    wait_idle();
    check_got("after_rst_load_words", V2R);
    send_frame(V1K, V1D, 1, 2, 0, 0);
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (s.m_valid) break;
      if (++n > 200) begin
        tfail("m_valid_wait");
        break;
      end
    end
    do_reset();
    send_frame(V3K, V2R, 1, 3, 0, 0);
    wait_idle();
    check_got("after_rst_out_words", V2D);
`ifdef AES_KEY_CACHE_EN
    send_frame(V1K, V1D, 1, 2, 0, 0);
    wait_idle();
    check_got("cache_full_words", V1R);
    send_frame('0, V1D, 0, 2, 0, 0);
    wait_idle();
    check_got("cache_reuse_words", V1R);
`endif
    for (int i = 0; i < 30; i++)
      send_frame({$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom(), $urandom(), $urandom()},
`ifdef AES_KEY_CACHE_EN
                 $urandom_range(0, 2) != 0,
`else
                 1'b1,
`endif
                 $urandom_range(1, 12), $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
- Hardware initiator for AES_CORE: accepts key and data as 32-bit words on a valid/ready stream and assembles them into 128-bit registers.
- Restarts the core for each block, waits for its finished flag, then returns the 128-bit result as four 32-bit output words.
- Sits between the system bus/DMA side and AES_CORE; direction (cipher/inverse) is set by the core's build, not by this block.

Parameters:
- CORE_RST_CYC, 2, cycles core_rst_n is held low per block (min 1)
- TIMEOUT_CYC, 64, max cycles in RUN before abort with error

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid&s_ready
- s_data  in  32  input word, most-significant word first
- s_new_key  in  1  sampled with first word of a frame (used only with AES_KEY_CACHE_EN)
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts
- m_data  out  32  result word, MSW first
- m_last  out  1  high on 4th result word
- err  out  1  one-cycle pulse on core timeout
- busy  out  1  high in any state but IDLE
- core_data_in  out  128  to AES_CORE.data_in
- core_key  out  128  to AES_CORE.key
- core_rst_n  out  1  to AES_CORE.rst_n
- core_data_out  in  128  from AES_CORE.data_out
- core_finished  in  1  from AES_CORE.finished

Behaviour:
- Reset (rst_n low, async): state IDLE, key/data/result regs 0, word counter 0, s_ready=0, m_valid=0, m_last=0, err=0, busy=0, core_rst_n=0.
- IDLE: s_ready=1. On first handshake, goes to LOAD_KEY (key word 0 stored into key[127:96]).
- LOAD_KEY: 4 words total, key[127:96] first. Then LOAD_DATA.
- LOAD_DATA: 4 words, data[127:96] first. Then RST_CORE.
- s_ready=1 only in IDLE/LOAD_KEY/LOAD_DATA. The counter advances only on handshake; stalls hold state.
- RST_CORE: core_rst_n=0 for CORE_RST_CYC cycles, then RUN. core_data_in/core_key are driven from regs and stay stable from RST_CORE through end of RUN.
- RUN: core_rst_n=1; cycle counter starts at 0.
  - core_finished sampled high: capture core_data_out into the result reg, go to OUT.
  - core_finished is ignored in the first RUN cycle (stale-flag guard).
  - Counter reaches TIMEOUT_CYC: err pulses for 1 cycle, result reg unchanged, core_rst_n driven 0, go to IDLE. No output words are produced.
- OUT: m_valid=1, m_data = result word idx (0 = [127:96]); idx advances on m_valid&m_ready; m_last=1 when idx=3.
  - m_data is stable while stalled.
  - After the last handshake go to IDLE, core_rst_n=0.
- core_rst_n is 0 in IDLE, LOAD_*, RST_CORE; 1 only in RUN and OUT.
- Back-to-back frames: IDLE re-entered the cycle after the last output handshake; a new frame may start there with no gap cycle.
- s_valid during RUN/OUT is not accepted (s_ready=0); no input is lost or buffered.

Optional Feature:
- Macro: AES_KEY_CACHE_EN
- Defined:
  - s_new_key is sampled on the first handshake in IDLE.
  - s_new_key=1: 8-word frame (key then data), as above.
  - s_new_key=0: the first word is data[127:96]; go directly to LOAD_DATA and reuse the stored key.
  - The key reg is cleared only by reset.
- Not defined: s_new_key is ignored; every frame is 8 words (key then data).

Test Plan:
- Core built with CIPHER: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> m_data 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; m_last on 4th word; err=0.
- Core built with CIPHER: key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734 -> 3925841d 02dc09fb dc118597 196a0b32. Core built inverse: key d014f9a8c9ee2589e13f0cc8b6630ca6, data 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8 885a308d 313198a2 e0370734.
- Random s_valid gaps and m_ready held low 5 cycles mid-output -> same words in order, m_data stable while stalled, no duplicated or dropped words.
- core_finished tied 0 -> err pulses exactly once, TIMEOUT_CYC cycles after RUN entry; no m_valid; next frame processed correctly.
- rst_n asserted during LOAD_DATA and during OUT -> all outputs at reset values immediately; a full frame afterwards gives the correct result.
- With AES_KEY_CACHE_EN: frame with s_new_key=1 (vector 1), then a 4-word frame with s_new_key=0 and data 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a again.
